// File: rtl/serial_adder_sequencer.sv
// Bit-serial WIDTH-bit adder controller driving a shared 1-bit full adder, LSB first,
// with valid/ready handshakes on both the operand and result sides.
module serial_adder_sequencer #(
    parameter int WIDTH  = 8,
    parameter int FA_LAT = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             busy
);

    localparam int            IW   = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
    localparam logic [1:0]    LAT  = 2'(FA_LAT);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IW-1:0]    i_q, i_d;
    logic [IW-1:0]    i_nxt;
    logic [1:0]       w_q, w_d;
    logic             c_q, c_d;
    logic             fa_a_q, fa_a_d;
    logic             fa_b_q, fa_b_d;
    logic             fa_cin_q, fa_cin_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    assign i_nxt = i_q + IW'(1);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        i_d      = i_q;
        w_d      = w_q;
        c_d      = c_q;
        fa_a_d   = fa_a_q;
        fa_b_d   = fa_b_q;
        fa_cin_d = fa_cin_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    c_d      = op_cin;
                    i_d      = '0;
                    w_d      = '0;
                    fa_a_d   = op_a[0];
                    fa_b_d   = op_b[0];
                    fa_cin_d = op_cin;
                    state_d  = STEP;
                end
            end
            STEP: begin
                if (w_q == LAT) begin
                    sum_d[i_q] = fa_s;
                    c_d        = fa_cout;
                    w_d        = '0;
                    if (i_q == LAST) begin
                        // c_q still holds the carry into the MSB here
                        cout_d  = fa_cout;
                        ovf_d   = c_q ^ fa_cout;
                        state_d = DONE;
                    end else begin
                        i_d      = i_nxt;
                        fa_a_d   = a_q[i_nxt];
                        fa_b_d   = b_q[i_nxt];
                        fa_cin_d = fa_cout;
                    end
                end else begin
                    w_d = w_q + 2'd1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            i_q      <= '0;
            w_q      <= '0;
            c_q      <= 1'b0;
            fa_a_q   <= 1'b0;
            fa_b_q   <= 1'b0;
            fa_cin_q <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            i_q      <= i_d;
            w_q      <= w_d;
            c_q      <= c_d;
            fa_a_q   <= fa_a_d;
            fa_b_q   <= fa_b_d;
            fa_cin_q <= fa_cin_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign fa_a      = fa_a_q;
    assign fa_b      = fa_b_q;
    assign fa_cin    = fa_cin_q;
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder_sequencer.sv
// Three sequencer instances (FA_LAT 1, 0, 3), each with a pipelined full-adder model,
// checked against plain-arithmetic expected sums, carries and overflow.
module tb_serial_adder_sequencer;

    logic       CLK;
    logic       RST;
    logic [2:0] in_valid, in_ready, res_valid, res_ready, busy;
    logic [2:0] fa_a, fa_b, fa_cin, fa_s, fa_cout;
    logic [2:0] op_cin, res_cout, res_ovf;
    logic [7:0] op_a    [3];
    logic [7:0] op_b    [3];
    logic [7:0] res_sum [3];

    int n_checks = 0;
    int n_pass   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        logic s_c, co_c;
        assign s_c  = fa_a[g] ^ fa_b[g] ^ fa_cin[g];
        assign co_c = (fa_a[g] & fa_b[g]) | (fa_cin[g] & (fa_a[g] ^ fa_b[g]));
        if (L == 0) begin : g_comb
            assign fa_s[g]    = s_c;
            assign fa_cout[g] = co_c;
        end else begin : g_pipe
            logic [L-1:0] sp, cp;
            always_ff @(posedge CLK) begin
                sp[0] <= s_c;
                cp[0] <= co_c;
                for (int x = 1; x < L; x++) begin
                    sp[x] <= sp[x-1];
                    cp[x] <= cp[x-1];
                end
            end
            assign fa_s[g]    = sp[L-1];
            assign fa_cout[g] = cp[L-1];
        end

        serial_adder_sequencer #(.WIDTH(8), .FA_LAT(L)) u_dut (
            .CLK      (CLK),
            .RST      (RST),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .op_a     (op_a[g]),
            .op_b     (op_b[g]),
            .op_cin   (op_cin[g]),
            .fa_a     (fa_a[g]),
            .fa_b     (fa_b[g]),
            .fa_cin   (fa_cin[g]),
            .fa_s     (fa_s[g]),
            .fa_cout  (fa_cout[g]),
            .res_valid(res_valid[g]),
            .res_ready(res_ready[g]),
            .res_sum  (res_sum[g]),
            .res_cout (res_cout[g]),
            .res_ovf  (res_ovf[g]),
            .busy     (busy[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    // Returns {ovf, cout, sum[7:0]} from integer arithmetic.
    function automatic logic [9:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic cin);
        int u, s, sa, sb;
        logic [7:0] sum;
        u   = int'(a) + int'(b) + int'(cin);
        sa  = $signed(a);
        sb  = $signed(b);
        s   = sa + sb + int'(cin);
        sum = 8'(u);
        return {(s > 127 || s < -128), (u > 255), sum};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic accept(input int k, input logic [7:0] a, input logic [7:0] b, input logic cin);
        int n;
        op_a[k]     = a;
        op_b[k]     = b;
        op_cin[k]   = cin;
        in_valid[k] = 1'b1;
        n = 0;
        while (!in_ready[k] && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        check("accept_timeout", 32'(n < 50), 1);
        @(posedge CLK); #1;
        in_valid[k] = 1'b0;
        op_a[k]     = ~a;
        op_b[k]     = ~b;
        op_cin[k]   = ~cin;
    endtask

    task automatic collect(input int k, input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input bit chk_fa);
        int L, cnt, j, carry;
        logic [7:0] m;
        logic [9:0] exp;
        L   = lat_of(k);
        cnt = 0;
        while (!res_valid[k] && cnt < 200) begin
            if (chk_fa && (cnt % (L + 1)) == 0 && (cnt / (L + 1)) < 8) begin
                j     = cnt / (L + 1);
                m     = 8'((1 << j) - 1);
                carry = ((int'(a & m) + int'(b & m) + int'(cin)) >> j) & 1;
                check($sformatf("fa_a[%0d]", j), 32'(fa_a[k]), 32'(a[j]));
                check($sformatf("fa_b[%0d]", j), 32'(fa_b[k]), 32'(b[j]));
                check($sformatf("fa_cin[%0d]", j), 32'(fa_cin[k]), 32'(carry));
                check("busy_step", 32'(busy[k]), 1);
            end
            @(posedge CLK); #1;
            cnt++;
        end
        check($sformatf("latency_lat%0d", L), 32'(cnt), 32'(8 * (L + 1)));
        exp = ref_add(a, b, cin);
        check("result", {22'd0, res_ovf[k], res_cout[k], res_sum[k]}, {22'd0, exp});
    endtask

    task automatic release_res(input int k);
        res_ready[k] = 1'b1;
        @(posedge CLK); #1;
        res_ready[k] = 1'b0;
        check("ready_after_res", {30'd0, in_ready[k], res_valid[k]}, 32'b10);
    endtask

    task automatic run(input int k, input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input bit chk_fa);
        accept(k, a, b, cin);
        collect(k, a, b, cin, chk_fa);
        release_res(k);
    endtask

    initial begin
        logic [9:0] exp;
        logic [7:0] ra, rb;
        logic       rc;
        bit         seen;
        RST       = 1'b1;
        in_valid  = '0;
        res_ready = '0;
        op_cin    = '0;
        for (int k = 0; k < 3; k++) begin
            op_a[k] = 8'hA5;
            op_b[k] = 8'h5A;
        end
        repeat (3) @(posedge CLK);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'b111);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fa", {29'd0, fa_a[0], fa_b[0], fa_cin[0]}, 0);
        check("rst_res", {22'd0, res_ovf[0], res_cout[0], res_sum[0]}, 0);
        RST = 1'b0;

        run(0, 8'h5A, 8'h3C, 1'b0, 1'b1);
        run(0, 8'hFF, 8'h01, 1'b0, 1'b0);
        run(0, 8'hFF, 8'h00, 1'b1, 1'b0);
        run(0, 8'h80, 8'h80, 1'b0, 1'b1);

        // Backpressure with a competing operand offer pending
        accept(0, 8'hC3, 8'h4D, 1'b1);
        collect(0, 8'hC3, 8'h4D, 1'b1, 1'b0);
        exp         = ref_add(8'hC3, 8'h4D, 1'b1);
        op_a[0]     = 8'h01;
        op_b[0]     = 8'h01;
        op_cin[0]   = 1'b0;
        in_valid[0] = 1'b1;
        for (int h = 0; h < 10; h++) begin
            @(posedge CLK); #1;
            check("bp_hold", {22'd0, res_ovf[0], res_cout[0], res_sum[0]}, {22'd0, exp});
            check("bp_flags", {30'd0, res_valid[0], in_ready[0]}, 32'b10);
        end
        res_ready[0] = 1'b1;
        @(posedge CLK); #1;
        res_ready[0] = 1'b0;
        check("bp_release", {30'd0, in_ready[0], res_valid[0]}, 32'b10);
        @(posedge CLK); #1;
        in_valid[0] = 1'b0;
        check("bp_second_accept", {30'd0, in_ready[0], busy[0]}, 32'b01);
        collect(0, 8'h01, 8'h01, 1'b0, 1'b0);
        release_res(0);

        // Reset during bit 3
        accept(0, 8'h5A, 8'h3C, 1'b0);
        repeat (6) begin
            @(posedge CLK); #1;
        end
        check("midop_fa_a3", 32'(fa_a[0]), 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("midop_flags", {29'd0, in_ready[0], res_valid[0], busy[0]}, 32'b100);
        check("midop_fa", {29'd0, fa_a[0], fa_b[0], fa_cin[0]}, 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (res_valid[0]) seen = 1'b1;
        end
        check("midop_no_result", 32'(seen), 0);
        run(0, 8'h10, 8'h20, 1'b0, 1'b0);

        // Random traffic with random backpressure on the FA_LAT=1 instance
        for (int t = 0; t < 20; t++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            accept(0, ra, rb, rc);
            collect(0, ra, rb, rc, (t % 4) == 0);
            repeat ($urandom_range(0, 3)) begin
                @(posedge CLK); #1;
            end
            check("rand_hold", {22'd0, res_ovf[0], res_cout[0], res_sum[0]}, {22'd0, ref_add(ra, rb, rc)});
            release_res(0);
        end

        // Latency sweep: FA_LAT=0 and FA_LAT=3
        for (int k = 1; k < 3; k++) begin
            for (int t = 0; t < 256; t++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rc = 1'($urandom);
                run(k, ra, rb, rc, t < 4);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
